// File: rtl/jstk_pkg.sv
// jstk_pkg -- shared definitions for the PmodJSTK poll controller.
//   jstk_state_t : sequencer states (IDLE, REQ, WAIT_LO, WAIT_HI, SETTLE, LATCH)
//   DIR_*        : Snake direction codes (00 up, 01 right, 10 down, 11 left)
//   AXIS_CENTER  : joystick axis rest value
//   CMD_HDR      : upper six bits of the LED command byte sent on DIN
package jstk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_LO,
    ST_WAIT_HI,
    ST_SETTLE,
    ST_LATCH
  } jstk_state_t;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [9:0] AXIS_CENTER = 10'd512;
  localparam logic [5:0] CMD_HDR     = 6'b100000;

endpackage

// File: rtl/jstk_dir_decode.sv
// jstk_dir_decode -- combinational joystick-to-direction decision.
// Applies a dead zone per axis, picks the dominant deflected axis (ties go to
// X), and rejects a 180-degree reversal of the current direction.
// Ports:
//   x, y     in  10  axis samples (0..1023, 512 = centre)
//   cur_dir  in  2   direction currently held
//   new_dir  out 2   direction to load (equals cur_dir when nothing changes)
//   chg      out 1   new_dir differs from cur_dir
module jstk_dir_decode
  import jstk_pkg::*;
#(
  parameter int DEAD_LO = 300,
  parameter int DEAD_HI = 724
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [1:0] cur_dir,
  output logic [1:0] new_dir,
  output logic       chg
);

  localparam logic [9:0] LO = 10'(DEAD_LO);
  localparam logic [9:0] HI = 10'(DEAD_HI);

  // Distance from centre; the extreme x=0 gives 512, which still fits 10 bits.
  function automatic logic [9:0] axis_mag(input logic [9:0] v);
    logic signed [10:0] d;
    d = $signed({1'b0, v}) - $signed({1'b0, AXIS_CENTER});
    return (d < 0) ? 10'(-d) : 10'(d);
  endfunction

  logic [9:0] dx;
  logic [9:0] dy;
  logic       x_def;
  logic       y_def;
  logic       x_win;
  logic       has_cand;
  logic [1:0] cand;

  always_comb begin
    dx       = axis_mag(x);
    dy       = axis_mag(y);
    x_def    = (x < LO) || (x > HI);
    y_def    = (y < LO) || (y > HI);
    x_win    = x_def && (!y_def || (dx >= dy));
    has_cand = x_def || y_def;
    if (x_win) cand = (x > HI) ? DIR_RIGHT : DIR_LEFT;
    else       cand = (y > HI) ? DIR_UP : DIR_DOWN;
    // A reversal is the current direction with its top bit flipped.
    chg      = has_cand && (cand != (cur_dir ^ 2'b10)) && (cand != cur_dir);
    new_dir  = chg ? cand : cur_dir;
  end

endmodule

// File: rtl/jstk_poll_ctrl.sv
// jstk_poll_ctrl -- periodic poll sequencer for the PmodJSTK SPI wrapper.
// Raises sndRec every POLL_CYCLES, follows the SS low/high handshake, then
// latches DOUT into x/y/buttons and updates the Snake direction.
// Optional watchdog: define JSTK_WDOG_EN to bound the SS wait with
// TIMEOUT_CYCLES and report a sticky err; otherwise err is tied low.
// Ports:
//   CLK, RST    clock, synchronous active-high reset
//   en          polling enable
//   led[1:0]    {LD2, LD1} request, sent in the DIN command byte
//   SS          slave select from PmodJSTK (monitored only)
//   DOUT[39:0]  PmodJSTK read data
//   sndRec      transaction request to PmodJSTK
//   DIN[7:0]    command byte, stable for a whole transaction
//   x_pos, y_pos, btn  latched sample; sample_vld pulses when loaded
//   dir, dir_chg       Snake direction and its change pulse
//   busy        sequencer not idle
//   err         sticky watchdog timeout
module jstk_poll_ctrl
  import jstk_pkg::*;
#(
  parameter int POLL_CYCLES    = 1_000_000,
  parameter int REQ_HOLD       = 3000,
  parameter int SETTLE         = 3000,
  parameter int DEAD_LO        = 300,
  parameter int DEAD_HI        = 724,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        en,
  input  logic [1:0]  led,
  input  logic        SS,
  input  logic [39:0] DOUT,
  output logic        sndRec,
  output logic [7:0]  DIN,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [2:0]  btn,
  output logic        sample_vld,
  output logic [1:0]  dir,
  output logic        dir_chg,
  output logic        busy,
  output logic        err
);

  localparam logic [31:0] POLL_LAST   = 32'(POLL_CYCLES - 1);
  localparam logic [31:0] REQ_LAST    = 32'(REQ_HOLD - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE - 1);

  jstk_state_t state;
  logic        ss_m;
  logic        ss_s;
  logic [31:0] poll_cnt;
  logic        poll_due;
  logic [31:0] cyc_cnt;
  logic        seen_low;
  logic        wdog_hit;

  // DOUT field unpacking: low byte first, then the two high bits of each axis.
  logic [9:0] dec_x;
  logic [9:0] dec_y;
  logic [2:0] dec_btn;
  logic [1:0] nxt_dir;
  logic       nxt_chg;
  logic       unused_dout;

  assign dec_x       = {DOUT[25:24], DOUT[39:32]};
  assign dec_y       = {DOUT[9:8], DOUT[23:16]};
  assign dec_btn     = DOUT[2:0];
  assign unused_dout = ^{DOUT[31:26], DOUT[15:10], DOUT[7:3]};

  jstk_dir_decode #(
    .DEAD_LO (DEAD_LO),
    .DEAD_HI (DEAD_HI)
  ) u_dir (
    .x       (dec_x),
    .y       (dec_y),
    .cur_dir (dir),
    .new_dir (nxt_dir),
    .chg     (nxt_chg)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      ss_m       <= 1'b1;
      ss_s       <= 1'b1;
      poll_cnt   <= '0;
      poll_due   <= 1'b0;
      state      <= ST_IDLE;
      cyc_cnt    <= '0;
      seen_low   <= 1'b0;
      sndRec     <= 1'b0;
      DIN        <= {CMD_HDR, 2'b00};
      x_pos      <= AXIS_CENTER;
      y_pos      <= AXIS_CENTER;
      btn        <= '0;
      sample_vld <= 1'b0;
      dir        <= DIR_RIGHT;
      dir_chg    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ss_m       <= SS;
      ss_s       <= ss_m;
      sample_vld <= 1'b0;
      dir_chg    <= 1'b0;

      // Poll timer: a wrap while busy just leaves poll_due set, so at most
      // one poll is pending. The wrap assignment below wins over the clear.
      if (state == ST_IDLE && poll_due) poll_due <= 1'b0;
      if (!en) begin
        poll_cnt <= '0;
        poll_due <= 1'b0;
      end else if (poll_cnt == POLL_LAST) begin
        poll_cnt <= '0;
        poll_due <= 1'b1;
      end else begin
        poll_cnt <= poll_cnt + 32'd1;
      end

      case (state)
        ST_IDLE: begin
          DIN      <= {CMD_HDR, led};
          seen_low <= 1'b0;
          cyc_cnt  <= '0;
          if (poll_due) begin
            state  <= ST_REQ;
            sndRec <= 1'b1;
            busy   <= 1'b1;
          end
        end
        ST_REQ: begin
          // SS may already have dropped and risen again before sndRec is released.
          if (!ss_s) seen_low <= 1'b1;
          if (cyc_cnt == REQ_LAST) begin
            state   <= ST_WAIT_LO;
            sndRec  <= 1'b0;
            cyc_cnt <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
          end
        end
        ST_WAIT_LO: begin
          if (seen_low || !ss_s) state <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (ss_s) begin
            state   <= ST_SETTLE;
            cyc_cnt <= '0;
          end
        end
        ST_SETTLE: begin
          if (cyc_cnt == SETTLE_LAST) state <= ST_LATCH;
          else                        cyc_cnt <= cyc_cnt + 32'd1;
        end
        ST_LATCH: begin
          x_pos      <= dec_x;
          y_pos      <= dec_y;
          btn        <= dec_btn;
          sample_vld <= 1'b1;
          dir        <= nxt_dir;
          dir_chg    <= nxt_chg;
          state      <= ST_IDLE;
          busy       <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          sndRec <= 1'b0;
          busy   <= 1'b0;
        end
      endcase

      // Watchdog abort: straight back to IDLE, skipping LATCH.
      if (wdog_hit) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end
    end
  end

`ifdef JSTK_WDOG_EN
  localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] wdog_cnt;
  logic        in_wait;

  // One budget shared across WAIT_LO, WAIT_HI and SETTLE.
  assign in_wait  = (state == ST_WAIT_LO) || (state == ST_WAIT_HI) ||
                    (state == ST_SETTLE);
  assign wdog_hit = in_wait && (wdog_cnt == WDOG_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wdog_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (in_wait && !wdog_hit) wdog_cnt <= wdog_cnt + 32'd1;
      else                      wdog_cnt <= '0;
      if (wdog_hit) err <= 1'b1;
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = (TIMEOUT_CYCLES == 0);
  assign wdog_hit    = 1'b0;
  assign err         = 1'b0;
`endif

endmodule
